// File: rtl/hazard_track.sv
// -----------------------------------------------------------------------------
// hazard_track
//
// Carries each instruction's register-file write enable and destination from
// ID through EX, MEM and WB. Detects load-use and MDU-busy hazards and produces
// the stall and flush controls used by the fetch/decode logic and the
// forwarding unit.
//
// Parameters
//   ADDR_RFILE  register-file address width
//   MDU_LAT     MDU occupancy in cycles after an accepted start (2..255)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   id_valid                       ID holds a real instruction
//   id_rfile_w, id_mem_read        ID writes the register file / is a load
//   id_wb_addr                     ID destination register
//   id_addr_rs, id_addr_rt         ID source registers
//   id_use_rs, id_use_rt           source actually read
//   id_mdu_start, id_mdu_use       ID starts an MDU op / reads HI/LO
//   branch_taken                   branch resolved taken in EX this cycle
//   stall_ctrl                     combinational stall (holds PC and IF/ID)
//   ex_rfile_w, ex_mem_read,
//   ex_wb_addr                     EX-stage copies
//   rfile_w_t2, wb_addr_t          MEM-stage write enable / destination
//   rfile_w_t3, wb_addr_t2         WB-stage write enable / destination
//   flush_ctrl_t                   branch_taken delayed one cycle
//   stall_ctrl_t2                  stall_ctrl delayed two cycles
//   mdu_busy                       MDU occupancy counter non-zero
// -----------------------------------------------------------------------------
module hazard_track #(
  parameter int ADDR_RFILE = 5,
  parameter int MDU_LAT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_rfile_w,
  input  logic                  id_mem_read,
  input  logic [ADDR_RFILE-1:0] id_wb_addr,
  input  logic [ADDR_RFILE-1:0] id_addr_rs,
  input  logic [ADDR_RFILE-1:0] id_addr_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_mdu_start,
  input  logic                  id_mdu_use,
  input  logic                  branch_taken,
  output logic                  stall_ctrl,
  output logic                  ex_rfile_w,
  output logic                  ex_mem_read,
  output logic [ADDR_RFILE-1:0] ex_wb_addr,
  output logic                  rfile_w_t2,
  output logic [ADDR_RFILE-1:0] wb_addr_t,
  output logic                  rfile_w_t3,
  output logic [ADDR_RFILE-1:0] wb_addr_t2,
  output logic                  flush_ctrl_t,
  output logic                  stall_ctrl_t2,
  output logic                  mdu_busy
);

  localparam logic [7:0] MDU_LAT_V = 8'(MDU_LAT);

  // EX stage
  logic                  ex_rfile_w_q, ex_rfile_w_d;
  logic                  ex_mem_read_q, ex_mem_read_d;
  logic [ADDR_RFILE-1:0] ex_wb_addr_q, ex_wb_addr_d;
  // MEM stage
  logic                  mem_rfile_w_q, mem_rfile_w_d;
  logic [ADDR_RFILE-1:0] mem_wb_addr_q, mem_wb_addr_d;
  // WB stage
  logic                  wb_rfile_w_q, wb_rfile_w_d;
  logic [ADDR_RFILE-1:0] wb_wb_addr_q, wb_wb_addr_d;
  // MDU occupancy and delayed controls
  logic [7:0]            mdu_cnt_q, mdu_cnt_d;
  logic                  flush_q, flush_d;
  logic                  stall_d1_q, stall_d1_d;
  logic                  stall_t2_q, stall_t2_d;

  logic stall_lu;
  logic stall_mdu;
  logic stall_w;
  logic busy_w;
  logic bubble;
  logic mdu_accept;

  always_comb begin
    busy_w = (mdu_cnt_q != 8'd0);

    // Only a real load in EX with a non-r0 destination can create a
    // load-use hazard; r0 is never forwarded so it never needs to stall.
    stall_lu = id_valid & ex_rfile_w_q & ex_mem_read_q &
               (ex_wb_addr_q != '0) &
               ((id_use_rs & (id_addr_rs == ex_wb_addr_q)) |
                (id_use_rt & (id_addr_rt == ex_wb_addr_q)));

    stall_mdu = id_valid & (id_mdu_use | id_mdu_start) & busy_w;

    // A taken branch flushes ID anyway, so it overrides any stall.
    stall_w = (stall_lu | stall_mdu) & ~branch_taken;

    bubble     = branch_taken | stall_w | ~id_valid;
    mdu_accept = id_valid & id_mdu_start & ~stall_w & ~branch_taken;

    // EX: bubble or the ID instruction (r0 writes pass through unchanged)
    ex_rfile_w_d  = 1'b0;
    ex_mem_read_d = 1'b0;
    ex_wb_addr_d  = '0;
    if (!bubble) begin
      ex_rfile_w_d  = id_rfile_w;
      ex_mem_read_d = id_mem_read;
      ex_wb_addr_d  = id_wb_addr;
    end

    // MEM and WB always advance; stalls never freeze them.
    mem_rfile_w_d = ex_rfile_w_q;
    mem_wb_addr_d = ex_wb_addr_q;
    wb_rfile_w_d  = mem_rfile_w_q;
    wb_wb_addr_d  = mem_wb_addr_q;

    // MDU counter: load on accepted start, else count down to 0 and hold.
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_accept) begin
      mdu_cnt_d = MDU_LAT_V;
    end else if (busy_w) begin
      mdu_cnt_d = mdu_cnt_q - 8'd1;
    end

    flush_d    = branch_taken;
    stall_d1_d = stall_w;
    stall_t2_d = stall_d1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rfile_w_q  <= 1'b0;
      ex_mem_read_q <= 1'b0;
      ex_wb_addr_q  <= '0;
      mem_rfile_w_q <= 1'b0;
      mem_wb_addr_q <= '0;
      wb_rfile_w_q  <= 1'b0;
      wb_wb_addr_q  <= '0;
      mdu_cnt_q     <= 8'd0;
      flush_q       <= 1'b0;
      stall_d1_q    <= 1'b0;
      stall_t2_q    <= 1'b0;
    end else begin
      ex_rfile_w_q  <= ex_rfile_w_d;
      ex_mem_read_q <= ex_mem_read_d;
      ex_wb_addr_q  <= ex_wb_addr_d;
      mem_rfile_w_q <= mem_rfile_w_d;
      mem_wb_addr_q <= mem_wb_addr_d;
      wb_rfile_w_q  <= wb_rfile_w_d;
      wb_wb_addr_q  <= wb_wb_addr_d;
      mdu_cnt_q     <= mdu_cnt_d;
      flush_q       <= flush_d;
      stall_d1_q    <= stall_d1_d;
      stall_t2_q    <= stall_t2_d;
    end
  end

  assign stall_ctrl    = stall_w;
  assign ex_rfile_w    = ex_rfile_w_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_wb_addr    = ex_wb_addr_q;
  assign rfile_w_t2    = mem_rfile_w_q;
  assign wb_addr_t     = mem_wb_addr_q;
  assign rfile_w_t3    = wb_rfile_w_q;
  assign wb_addr_t2    = wb_wb_addr_q;
  assign flush_ctrl_t  = flush_q;
  assign stall_ctrl_t2 = stall_t2_q;
  assign mdu_busy      = busy_w;

endmodule

// File: tb/tb_hazard_track.sv
// Directed bench for hazard_track: a vector table for single-cycle behaviour
// plus hand-written sequences for reset, MDU occupancy and branch squash.
module tb_hazard_track;

  logic       clk;
  logic       rst;
  logic       id_valid, id_rfile_w, id_mem_read;
  logic [4:0] id_wb_addr, id_addr_rs, id_addr_rt;
  logic       id_use_rs, id_use_rt, id_mdu_start, id_mdu_use, branch_taken;
  logic       stall_ctrl, ex_rfile_w, ex_mem_read;
  logic [4:0] ex_wb_addr, wb_addr_t, wb_addr_t2;
  logic       rfile_w_t2, rfile_w_t3, flush_ctrl_t, stall_ctrl_t2, mdu_busy;

  int checks   = 0;
  int failures = 0;

  hazard_track #(.ADDR_RFILE(5), .MDU_LAT(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rfile_w(id_rfile_w), .id_mem_read(id_mem_read),
    .id_wb_addr(id_wb_addr), .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_mdu_start(id_mdu_start), .id_mdu_use(id_mdu_use),
    .branch_taken(branch_taken),
    .stall_ctrl(stall_ctrl), .ex_rfile_w(ex_rfile_w), .ex_mem_read(ex_mem_read),
    .ex_wb_addr(ex_wb_addr), .rfile_w_t2(rfile_w_t2), .wb_addr_t(wb_addr_t),
    .rfile_w_t3(rfile_w_t3), .wb_addr_t2(wb_addr_t2),
    .flush_ctrl_t(flush_ctrl_t), .stall_ctrl_t2(stall_ctrl_t2),
    .mdu_busy(mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, v, w, mr;
    logic [4:0] a, rs, rt;
    logic       urs, urt, ms, mu, br;
    logic       e_stall;
    logic       e_exw, e_exmr;
    logic [4:0] e_exa;
    logic       e_mw;
    logic [4:0] e_ma;
    logic       e_ww;
    logic [4:0] e_wa;
    logic       e_fl, e_st2, e_busy;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mv(string n, logic r, logic v, logic w, logic mr,
      logic [4:0] a, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
      logic ms, logic mu, logic br, logic est, logic exw, logic exmr,
      logic [4:0] exa, logic mw, logic [4:0] ma, logic ww, logic [4:0] wa,
      logic fl, logic st2, logic busy);
    vec_t t;
    t.name = n; t.rst = r; t.v = v; t.w = w; t.mr = mr; t.a = a;
    t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.ms = ms; t.mu = mu;
    t.br = br; t.e_stall = est; t.e_exw = exw; t.e_exmr = exmr; t.e_exa = exa;
    t.e_mw = mw; t.e_ma = ma; t.e_ww = ww; t.e_wa = wa; t.e_fl = fl;
    t.e_st2 = st2; t.e_busy = busy;
    return t;
  endfunction

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic w, input logic mr,
      input logic [4:0] a, input logic [4:0] rs, input logic [4:0] rt,
      input logic urs, input logic urt, input logic ms, input logic mu,
      input logic br);
    id_valid = v; id_rfile_w = w; id_mem_read = mr; id_wb_addr = a;
    id_addr_rs = rs; id_addr_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_mdu_start = ms; id_mdu_use = mu; branch_taken = br;
  endtask

  task automatic check_regs(input string n, input logic exw, input logic exmr,
      input logic [4:0] exa, input logic mw, input logic [4:0] ma,
      input logic ww, input logic [4:0] wa, input logic fl, input logic st2,
      input logic busy);
    chk({n, ".ex_rfile_w"}, 8'(ex_rfile_w), 8'(exw));
    chk({n, ".ex_mem_read"}, 8'(ex_mem_read), 8'(exmr));
    chk({n, ".ex_wb_addr"}, 8'(ex_wb_addr), 8'(exa));
    chk({n, ".rfile_w_t2"}, 8'(rfile_w_t2), 8'(mw));
    chk({n, ".wb_addr_t"}, 8'(wb_addr_t), 8'(ma));
    chk({n, ".rfile_w_t3"}, 8'(rfile_w_t3), 8'(ww));
    chk({n, ".wb_addr_t2"}, 8'(wb_addr_t2), 8'(wa));
    chk({n, ".flush_ctrl_t"}, 8'(flush_ctrl_t), 8'(fl));
    chk({n, ".stall_ctrl_t2"}, 8'(stall_ctrl_t2), 8'(st2));
    chk({n, ".mdu_busy"}, 8'(mdu_busy), 8'(busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    set_in(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(31, 0)),
           5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    // Table, starting from a freshly reset pipeline (all stages empty).
    //            name        rst v w mr a   rs  rt urs urt ms mu br  stall exw exmr exa mw ma ww wa fl st2 busy
    tbl[0]  = mv("ld_r5",     0, 1,1,1, 5,  1,  2, 1, 1, 0, 0, 0,  0,   1, 1, 5,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mv("lu_stall",  0, 1,1,0, 6,  5,  0, 1, 0, 0, 0, 0,  1,   0, 0, 0,  1, 5, 0, 0, 0, 0, 0);
    tbl[2]  = mv("lu_retry",  0, 1,1,0, 6,  5,  0, 1, 0, 0, 0, 0,  0,   1, 0, 6,  0, 0, 1, 5, 0, 1, 0);
    tbl[3]  = mv("ld_r0",     0, 1,1,1, 0,  3,  4, 1, 1, 0, 0, 0,  0,   1, 1, 0,  1, 6, 0, 0, 0, 0, 0);
    tbl[4]  = mv("r0_use",    0, 1,1,0, 8,  0,  0, 1, 1, 0, 0, 0,  0,   1, 0, 8,  1, 0, 1, 6, 0, 0, 0);
    tbl[5]  = mv("ld_r9",     0, 1,1,1, 9,  1,  2, 1, 1, 0, 0, 0,  0,   1, 1, 9,  1, 8, 1, 0, 0, 0, 0);
    tbl[6]  = mv("br_flush",  0, 1,1,0, 7,  0,  9, 0, 1, 0, 0, 1,  0,   0, 0, 0,  1, 9, 1, 8, 1, 0, 0);
    tbl[7]  = mv("post_br",   0, 0,0,0, 0,  0,  0, 0, 0, 0, 0, 0,  0,   0, 0, 0,  0, 0, 1, 9, 0, 0, 0);
    tbl[8]  = mv("alu_r3",    0, 1,1,0, 3,  0,  0, 0, 0, 0, 0, 0,  0,   1, 0, 3,  0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mv("alu_r4",    0, 1,1,0, 4,  0,  0, 0, 0, 0, 0, 0,  0,   1, 0, 4,  1, 3, 0, 0, 0, 0, 0);
    tbl[10] = mv("alu_r3b",   0, 1,1,0, 3,  0,  0, 0, 0, 0, 0, 0,  0,   1, 0, 3,  1, 4, 1, 3, 0, 0, 0);
    tbl[11] = mv("chain_d1",  0, 0,0,0, 0,  0,  0, 0, 0, 0, 0, 0,  0,   0, 0, 0,  1, 3, 1, 4, 0, 0, 0);
    tbl[12] = mv("chain_d2",  0, 0,0,0, 0,  0,  0, 0, 0, 0, 0, 0,  0,   0, 0, 0,  0, 0, 1, 3, 0, 0, 0);
    tbl[13] = mv("alu_r5",    0, 1,1,0, 5,  0,  0, 0, 0, 0, 0, 0,  0,   1, 0, 5,  0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mv("alu_r6",    0, 1,1,0, 6,  0,  0, 0, 0, 0, 0, 0,  0,   1, 0, 6,  1, 5, 0, 0, 0, 0, 0);
    tbl[15] = mv("mid_rst",   1, 1,1,0, 7,  0,  0, 0, 0, 1, 0, 0,  0,   0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

    // Reset held two cycles with random inputs.
    rst = 1'b1;
    rand_in();
    tick();
    rand_in();
    tick();
    check_regs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset.stall_ctrl", 8'(stall_ctrl), 8'd0);
    $display("txn reset: registered outputs cleared");
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst;
      set_in(tbl[i].v, tbl[i].w, tbl[i].mr, tbl[i].a, tbl[i].rs, tbl[i].rt,
             tbl[i].urs, tbl[i].urt, tbl[i].ms, tbl[i].mu, tbl[i].br);
      #1;
      chk({tbl[i].name, ".stall_ctrl"}, 8'(stall_ctrl), 8'(tbl[i].e_stall));
      tick();
      check_regs(tbl[i].name, tbl[i].e_exw, tbl[i].e_exmr, tbl[i].e_exa,
                 tbl[i].e_mw, tbl[i].e_ma, tbl[i].e_ww, tbl[i].e_wa,
                 tbl[i].e_fl, tbl[i].e_st2, tbl[i].e_busy);
      $display("txn %0d %s: stall=%0b ex=%0b/%0d mem=%0b/%0d wb=%0b/%0d",
               i, tbl[i].name, stall_ctrl, ex_rfile_w, ex_wb_addr,
               rfile_w_t2, wb_addr_t, rfile_w_t3, wb_addr_t2);
    end
    rst = 1'b0;

    // MDU start squashed by a concurrent taken branch.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    chk("mdu_squash.mdu_busy", 8'(mdu_busy), 8'd0);
    $display("txn mdu_squash: busy=%0b", mdu_busy);

    // MDU start accepted at edge 0, then mfhi waits in ID.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("mdu_start.stall_ctrl", 8'(stall_ctrl), 8'd0);
    tick();
    set_in(1, 1, 0, 10, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("mdu_cyc%0d.mdu_busy", k), 8'(mdu_busy), 8'd1);
      chk($sformatf("mdu_cyc%0d.stall_ctrl", k), 8'(stall_ctrl), 8'd1);
      chk($sformatf("mdu_cyc%0d.ex_rfile_w", k), 8'(ex_rfile_w), 8'd0);
      tick();
    end
    #1;
    chk("mdu_done.mdu_busy", 8'(mdu_busy), 8'd0);
    chk("mdu_done.stall_ctrl", 8'(stall_ctrl), 8'd0);
    tick();
    chk("mfhi_ex.ex_rfile_w", 8'(ex_rfile_w), 8'd1);
    chk("mfhi_ex.ex_wb_addr", 8'(ex_wb_addr), 8'd10);
    chk("mfhi_ex.stall_ctrl_t2", 8'(stall_ctrl_t2), 8'd1);
    $display("txn mdu: mfhi entered EX dest=%0d", ex_wb_addr);

    // Second start while busy stalls for the same span, then reloads.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("mdu2_cyc%0d.stall_ctrl", k), 8'(stall_ctrl), 8'd1);
      tick();
    end
    #1;
    chk("mdu2_accept.stall_ctrl", 8'(stall_ctrl), 8'd0);
    tick();
    chk("mdu2_reload.mdu_busy", 8'(mdu_busy), 8'd1);
    $display("txn mdu2: second start accepted, busy=%0b", mdu_busy);

    // Reset while busy abandons the MDU and ends the stall.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("mdu_rst_pre.stall_ctrl", 8'(stall_ctrl), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mdu_rst.mdu_busy", 8'(mdu_busy), 8'd0);
    chk("mdu_rst.stall_ctrl", 8'(stall_ctrl), 8'd0);
    $display("txn mdu_rst: busy=%0b stall=%0b", mdu_busy, stall_ctrl);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
